// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers,
// with bursts of up to MAX_BURST beats per grant. Optional stall counter: FIFO_WRITE_ARBITER_STALL_CNT_EN.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int IDX_W     = 2,
  parameter int MAX_BURST = 4,
  parameter int BURST_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_write_enable,
  output logic [WIDTH-1:0]         fifo_data_in,
  output logic [IDX_W-1:0]         grant_id,
  output logic                     busy
`ifdef FIFO_WRITE_ARBITER_STALL_CNT_EN
  ,
  output logic [15:0]              stall_count
`endif
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   grant_nxt, last_grant, last_nxt, cand_idx, sel_idx;
  logic [BURST_W-1:0] beat_cnt, beat_nxt;
  logic               sel_found, gnt_valid, accept;

  assign gnt_valid = req_valid[grant_id];

  // Search starts just after the last granted requester so every producer takes its turn.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = grant_id;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!sel_found && req_valid[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt         = state;
    grant_nxt         = grant_id;
    last_nxt          = last_grant;
    beat_nxt          = beat_cnt;
    req_ready         = '0;
    fifo_write_enable = 1'b0;
    fifo_data_in      = '0;
    busy              = 1'b0;
    accept            = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          grant_nxt = sel_idx;
          beat_nxt  = '0;
          state_nxt = BURST;
        end
      end
      BURST: begin
        busy                = 1'b1;
        req_ready[grant_id] = !fifo_full;
        accept              = gnt_valid && !fifo_full;
        fifo_write_enable   = accept;
        fifo_data_in        = req_data[grant_id*WIDTH +: WIDTH];
        if (accept)
          beat_nxt = beat_cnt + BURST_W'(1);
        // A dropped valid ends the grant early; full alone never does.
        if (!gnt_valid || (accept && beat_cnt == BURST_W'(MAX_BURST - 1))) begin
          state_nxt = IDLE;
          last_nxt  = grant_id;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      beat_cnt   <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else begin
      state      <= state_nxt;
      grant_id   <= grant_nxt;
      beat_cnt   <= beat_nxt;
      last_grant <= last_nxt;
    end
  end

`ifdef FIFO_WRITE_ARBITER_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= '0;
    else if (busy && gnt_valid && fifo_full && stall_count != 16'hFFFF)
      stall_count <= stall_count + 16'd1;
  end
`endif

endmodule
